// File: rtl/dmem_access_ctrl.sv
// ME-stage data-memory sequencer: issues one request per load/store, stalls the
// pipeline until the memory acks or the access times out, and tracks errors/counters.
//
// state  | meaning
// IDLE   | no access in flight; evaluates the ME-stage instruction
// ACCESS | request outstanding, waiting for mem_ack or timeout
// DONE   | access finished; pipeline advances this cycle
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ans_me,
  input  logic [31:0]      b_me,
  input  logic             wmem_me,
  input  logic             m2reg_me,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      rdata_me,
  output logic             rdata_vld,
  output logic             err_timeout,
  output logic             err_align,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       is_load;
  logic       acc;
  logic       misaligned;

  assign acc        = wmem_me | m2reg_me;
  assign misaligned = (ans_me[1:0] != 2'b00);
  assign stall      = (state == ACCESS) || ((state == IDLE) && acc);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= 8'd0;
      is_load     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      rdata_me    <= 32'd0;
      rdata_vld   <= 1'b0;
      err_timeout <= 1'b0;
      err_align   <= 1'b0;
      acc_cnt     <= '0;
      stall_cnt   <= '0;
    end else begin
      rdata_vld <= 1'b0;
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_ONE;

      case (state)
        IDLE: begin
          if (acc) begin
            // a store wins when both requests are raised
            is_load <= ~wmem_me;
            if (misaligned) begin
              state     <= DONE;
              err_align <= 1'b1;
              rdata_me  <= 32'd0;
              rdata_vld <= ~wmem_me;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= wmem_me;
              mem_addr  <= {ans_me[31:2], 2'b00};
              mem_wdata <= b_me;
              tmo_cnt   <= 8'd0;
            end
          end
        end

        ACCESS: begin
          if (mem_ack) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            acc_cnt   <= acc_cnt + CNT_ONE;
            rdata_vld <= is_load;
            if (is_load)
              rdata_me <= mem_rdata;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= DONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            err_timeout <= 1'b1;
            rdata_me    <= 32'd0;
            rdata_vld   <= is_load;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the ME-stage data-memory access for the 5-stage pipeline CPU against a variable-latency data memory.
- Sits between the EX->ME pipeline register outputs and the data memory.
- Raises a pipeline-wide stall while a load or store is outstanding, returns load data to the ME->WB path, and keeps sticky error flags plus performance counters.

Parameters:
- TIMEOUT, 16, ACCESS-state cycles without mem_ack before the access is abandoned (range 2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ans_me  in  32  ME-stage ALU result, used as the byte address.
- b_me  in  32  ME-stage store data.
- wmem_me  in  1  ME-stage store request.
- m2reg_me  in  1  ME-stage load request.
- stall  out  1  hold the PC and all pipeline registers (combinational).
- mem_req  out  1  memory request (registered).
- mem_we  out  1  1 = write (registered).
- mem_addr  out  32  word-aligned address (registered).
- mem_wdata  out  32  store data (registered).
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  32  read data, valid when mem_ack = 1.
- rdata_me  out  32  load result to the ME->WB register.
- rdata_vld  out  1  rdata_me valid this cycle.
- err_timeout  out  1  sticky: an access timed out.
- err_align  out  1  sticky: misaligned address.
- acc_cnt  out  CNT_W  completed accesses, wraps.
- stall_cnt  out  CNT_W  cycles with stall = 1, saturates at all-ones.

Behaviour:
- Access condition: acc = wmem_me | m2reg_me. If both are high, treat it as a store (mem_we = 1) with no error.
- Reset, synchronous: on the next edge go to IDLE. mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata_me = 0, rdata_vld = 0, both err flags = 0, both counters = 0, timeout counter = 0.
- Reset mid-access abandons the access. A late mem_ack after reset is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE with acc = 0: stay in IDLE; stall = 0.
- IDLE with acc = 1 and ans_me[1:0] = 0:
  - stall = 1.
  - Next edge: go to ACCESS, mem_req <= 1, mem_we <= wmem_me, mem_addr <= ans_me, mem_wdata <= b_me, timeout counter <= 0.
- IDLE with acc = 1 and ans_me[1:0] != 0:
  - stall = 1.
  - Next edge: go to DONE with no memory request, err_align <= 1, rdata_me <= 0.
- ACCESS: stall = 1. mem_addr, mem_we and mem_wdata stay stable.
  - mem_ack = 1: next edge goes to DONE, mem_req <= 0, rdata_me <= mem_rdata for a load (unchanged for a store), acc_cnt increments.
  - mem_ack = 0 and timeout counter = TIMEOUT-1: next edge goes to DONE, mem_req <= 0, err_timeout <= 1, rdata_me <= 0.
  - Otherwise the timeout counter increments.
  - mem_ack and the timeout hitting in the same cycle: mem_ack wins, no error.
- DONE:
  - stall = 0; rdata_vld = 1 only if the access was a load.
  - The pipeline advances on this edge; next state is IDLE unconditionally.
  - The next instruction is evaluated in IDLE, so back-to-back memory operations each pay the full sequence.
- Latency:
  - A memory acking on the first ACCESS cycle gives 2 stall cycles plus the DONE cycle.
  - General case: stall cycles = 1 + (cycles spent in ACCESS).
- mem_ack outside ACCESS is ignored.
- stall_cnt increments every cycle stall = 1 and holds at max.
- Error flags clear only on reset.

Test Plan:
- Load, ans_me = 0x0000_0010, mem_ack on the 3rd ACCESS cycle with mem_rdata = 0xCAFE_F00D -> mem_addr = 0x10 and mem_we = 0; stall high 4 cycles; DONE gives rdata_me = 0xCAFEF00D with rdata_vld = 1; acc_cnt = 1, stall_cnt = 4.
- Store, b_me = 0x1234_5678, immediate ack -> mem_we = 1 and mem_wdata = 0x12345678 for one cycle; stall high 2 cycles; rdata_vld = 0; acc_cnt increments.
- No ack, TIMEOUT = 16 -> stall for 17 cycles, then DONE with err_timeout = 1 and rdata_me = 0; err_timeout stays 1 through later good accesses until reset.
- Load to ans_me = 0x0000_0006 -> no mem_req at any time; err_align = 1; stall high 1 cycle; rdata_me = 0 with rdata_vld = 1.
- Reset asserted in the 2nd ACCESS cycle, mem_ack pulsed the next cycle -> mem_req = 0 after the reset edge; state IDLE; all outputs and counters zero; the ack has no effect.
- Both wmem_me and m2reg_me high, with the ack and the timeout landing in the same cycle -> mem_we = 1; DONE with err_timeout = 0; acc_cnt increments.
